// File: rtl/burst_mem_pkg.sv
// Shared constants and FSM state type for the burst memory responder.
package burst_mem_pkg;
    localparam int unsigned BEATS    = 4;
    localparam int unsigned BEAT_W   = 64;
    localparam int unsigned LINE_W   = 256;
    localparam int unsigned OFFSET_W = 5;

    typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_e;
endpackage

// File: rtl/burst_mem_array.sv
// Word-addressed backing store: one synchronous write port, one asynchronous read port.
module burst_mem_array
    import burst_mem_pkg::*;
#(
    parameter int unsigned Depth = 64,
    parameter int unsigned AddrW = 6
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AddrW-1:0]  waddr_i,
    input  logic [BEAT_W-1:0] wdata_i,
    input  logic [AddrW-1:0]  raddr_i,
    output logic [BEAT_W-1:0] rdata_o
);
    logic [BEAT_W-1:0] mem_q [Depth];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/burst_memory_responder.sv
// Memory-side responder for 4-beat 64-bit line bursts with a fixed access latency.
module burst_memory_responder
    import burst_mem_pkg::*;
#(
    parameter int unsigned LINES   = 16,
    parameter int unsigned LATENCY = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [31:0]       address_i,
    input  logic              read_i,
    input  logic              write_i,
    input  logic [BEAT_W-1:0] burst_i,
    output logic [BEAT_W-1:0] burst_o,
    output logic              resp_o
);
    localparam int unsigned IdxW    = $clog2(LINES);
    localparam int unsigned AddrW   = IdxW + 2;
    localparam logic [3:0]  CntLoad = 4'(LATENCY - 1);
    localparam logic [1:0]  LastBeat = 2'(BEATS - 1);

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              is_read_q, is_read_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [1:0]        beat_q, beat_d;
    logic              resp_q, resp_d;
    logic [BEAT_W-1:0] burst_q, burst_d;

    logic              req_held;
    logic              we;
    logic [1:0]        rd_beat;
    logic [AddrW-1:0]  rd_addr;
    logic [AddrW-1:0]  wr_addr;
    logic [BEAT_W-1:0] rd_data;
    logic              unused_addr;

    assign unused_addr = ^{address_i[31:OFFSET_W+IdxW], address_i[OFFSET_W-1:0]};

    // Only the signal that started the transaction keeps it alive.
    assign req_held = is_read_q ? read_i : write_i;
    assign we       = (state_q == BURST) && !is_read_q && write_i;
    assign wr_addr  = {idx_q, beat_q};

    // Look one beat ahead so burst_o is registered in the cycle resp_o is high.
    always_comb begin
        rd_beat = 2'd0;
        if (state_q == BURST) begin
            rd_beat = beat_q + 2'd1;
        end
        rd_addr = {idx_q, rd_beat};
    end

    burst_mem_array #(
        .Depth(LINES * BEATS),
        .AddrW(AddrW)
    ) u_array (
        .clk    (clk),
        .we_i   (we),
        .waddr_i(wr_addr),
        .wdata_i(burst_i),
        .raddr_i(rd_addr),
        .rdata_o(rd_data)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        is_read_d = is_read_q;
        cnt_d     = cnt_q;
        beat_d    = beat_q;
        resp_d    = resp_q;
        burst_d   = burst_q;
        unique case (state_q)
            IDLE: begin
                if (read_i || write_i) begin
                    state_d   = WAIT;
                    idx_d     = address_i[OFFSET_W +: IdxW];
                    is_read_d = read_i;
                    cnt_d     = CntLoad;
                end
            end
            WAIT: begin
                if (!req_held) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = BURST;
                    beat_d  = 2'd0;
                    resp_d  = 1'b1;
                    burst_d = is_read_q ? rd_data : '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            BURST: begin
                if (!req_held || beat_q == LastBeat) begin
                    state_d = req_held ? DONE : IDLE;
                    resp_d  = 1'b0;
                    burst_d = '0;
                end else begin
                    beat_d  = beat_q + 2'd1;
                    burst_d = is_read_q ? rd_data : '0;
                end
            end
            DONE: begin
                if (!read_i && !write_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            is_read_q <= 1'b0;
            cnt_q     <= 4'd0;
            beat_q    <= 2'd0;
            resp_q    <= 1'b0;
            burst_q   <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            is_read_q <= is_read_d;
            cnt_q     <= cnt_d;
            beat_q    <= beat_d;
            resp_q    <= resp_d;
            burst_q   <= burst_d;
        end
    end

    assign resp_o  = resp_q;
    assign burst_o = burst_q;
endmodule
